// File: rtl/bus_arb_pkg.sv
// Shared defaults and helpers for the bus host arbiter.
// Imported by the arbiter, its owner FIFO and its port interface.
package bus_arb_pkg;

  localparam int unsigned DefNrHosts        = 2;
  localparam int unsigned DefDataWidth      = 32;
  localparam int unsigned DefAddressWidth   = 32;
  localparam int unsigned DefMaxOutstanding = 2;
  localparam int unsigned DefTimeoutCycles  = 64;

  localparam int unsigned WdogCntWidth = 16;

  // Index width for n entries; never below 1 bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 0;
    while ((32'd1 << w) < n) w++;
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/bus_host_arbiter_if.sv
// Host-side and bus-side signals of the bus host arbiter.
// slave: the arbiter view; master: requesters plus bus view.
interface bus_host_arbiter_if
  import bus_arb_pkg::*;
#(
  parameter int unsigned NrHosts      = DefNrHosts,
  parameter int unsigned DataWidth    = DefDataWidth,
  parameter int unsigned AddressWidth = DefAddressWidth
);

  logic                    host_req_i    [NrHosts];
  logic                    host_gnt_o    [NrHosts];
  logic [AddressWidth-1:0] host_addr_i   [NrHosts];
  logic                    host_we_i     [NrHosts];
  logic [3:0]              host_be_i     [NrHosts];
  logic [DataWidth-1:0]    host_wdata_i  [NrHosts];
  logic                    host_rvalid_o [NrHosts];
  logic [DataWidth-1:0]    host_rdata_o  [NrHosts];
  logic                    host_err_o    [NrHosts];

  logic                    bus_req_o;
  logic                    bus_gnt_i;
  logic [AddressWidth-1:0] bus_addr_o;
  logic                    bus_we_o;
  logic [3:0]              bus_be_o;
  logic [DataWidth-1:0]    bus_wdata_o;
  logic                    bus_rvalid_i;
  logic [DataWidth-1:0]    bus_rdata_i;
  logic                    bus_err_i;

  modport slave (
    input  host_req_i, host_addr_i, host_we_i,
    input  host_be_i, host_wdata_i,
    output host_gnt_o, host_rvalid_o,
    output host_rdata_o, host_err_o,
    output bus_req_o, bus_addr_o, bus_we_o,
    output bus_be_o, bus_wdata_o,
    input  bus_gnt_i, bus_rvalid_i,
    input  bus_rdata_i, bus_err_i
  );

  modport master (
    output host_req_i, host_addr_i, host_we_i,
    output host_be_i, host_wdata_i,
    input  host_gnt_o, host_rvalid_o,
    input  host_rdata_o, host_err_o,
    input  bus_req_o, bus_addr_o, bus_we_o,
    input  bus_be_o, bus_wdata_o,
    output bus_gnt_i, bus_rvalid_i,
    output bus_rdata_i, bus_err_i
  );

endinterface

// File: rtl/arb_owner_fifo.sv
// In-order FIFO of host indices, one entry per outstanding
// bus transaction; synchronous active-low reset.
module arb_owner_fifo
  import bus_arb_pkg::*;
#(
  parameter int unsigned Depth = DefMaxOutstanding,
  parameter int unsigned Width = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [Width-1:0] head
);

  localparam int unsigned PtrW = clog2(Depth);
  localparam int unsigned CntW = clog2(Depth + 1);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  rd_ptr, wr_ptr;
  logic [CntW-1:0]  count;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] nxt(
    input logic [PtrW-1:0] p
  );
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CntW'(Depth));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bus_host_arbiter.sv
// Round-robin arbiter sharing one bus host port among NrHosts.
// Optional response watchdog enabled with `define ARB_WDOG_EN.
module bus_host_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned NrHosts        = DefNrHosts,
  parameter int unsigned DataWidth      = DefDataWidth,
  parameter int unsigned AddressWidth   = DefAddressWidth,
  parameter int unsigned MaxOutstanding = DefMaxOutstanding,
  parameter int unsigned TimeoutCycles  = DefTimeoutCycles
) (
  input logic ck_i,
  input logic rst_ni,
  bus_host_arbiter_if.slave io
);

  localparam int unsigned IdxW = clog2(NrHosts);

  logic [IdxW-1:0] ptr, win, cand, head;
  logic found, full, empty;
  logic bus_req, grant, resp, pop, timeout;

  if (MaxOutstanding < 1 ||
      (MaxOutstanding & (MaxOutstanding - 1)) != 0 ||
      TimeoutCycles < 1 ||
      TimeoutCycles >= (1 << WdogCntWidth)) begin : g_bad_cfg
    $error("bus_host_arbiter: bad parameters");
  end

  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NrHosts; i++) begin
      cand = IdxW'((32'(ptr) + i) % NrHosts);
      if (!found && io.host_req_i[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Full blocks requests regardless of a same-cycle pop.
  assign bus_req = rst_ni & found & ~full;
  assign grant   = bus_req & io.bus_gnt_i;
  assign resp    = rst_ni & io.bus_rvalid_i & ~empty;
  assign pop     = resp | timeout;

`ifdef ARB_WDOG_EN
  logic [WdogCntWidth-1:0] wdog;

  assign timeout = rst_ni & ~empty & ~io.bus_rvalid_i &
    (wdog == WdogCntWidth'(TimeoutCycles - 1));

  always_ff @(posedge ck_i) begin
    if (!rst_ni || empty || pop) wdog <= '0;
    else                         wdog <= wdog + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    io.bus_req_o   = bus_req;
    io.bus_addr_o  = found ? io.host_addr_i[win]  : '0;
    io.bus_we_o    = found ? io.host_we_i[win]    : 1'b0;
    io.bus_be_o    = found ? io.host_be_i[win]    : '0;
    io.bus_wdata_o = found ? io.host_wdata_i[win] : '0;
    for (int unsigned h = 0; h < NrHosts; h++) begin
      io.host_gnt_o[h]    = grant & (win == IdxW'(h));
      io.host_rvalid_o[h] = pop & (head == IdxW'(h));
      io.host_err_o[h]    = pop & (head == IdxW'(h)) &
                            (timeout | io.bus_err_i);
      io.host_rdata_o[h]  = timeout ? '0 : io.bus_rdata_i;
    end
  end

  always_ff @(posedge ck_i) begin
    if (!rst_ni)    ptr <= '0;
    else if (grant) ptr <= (win == IdxW'(NrHosts - 1)) ?
                           '0 : win + 1'b1;
  end

  arb_owner_fifo #(
    .Depth (MaxOutstanding),
    .Width (IdxW)
  ) u_owner_fifo (
    .clk   (ck_i),
    .rst_n (rst_ni),
    .push  (grant),
    .pop   (pop),
    .din   (win),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

`ifndef SYNTHESIS
  always_ff @(posedge ck_i) begin
    if (rst_ni && io.bus_rvalid_i && empty)
      $error("bus_host_arbiter: stray bus response dropped");
  end
`endif

endmodule
